// File: rtl/reg_file.sv
// Purpose : 8-entry, 2-read / 1-write register file with valid flags and a saturating write counter.
// Latency : reads are combinational (zero cycles); writes land on the rising CLK edge.
// Backpr. : none; every write with RESET low is accepted, and reads are always available.
//
// Ports
//   CLK          single clock, all state updates on the rising edge
//   RESET        synchronous active-high reset; it wins over WRITE on the same edge
//   IN           write data (DATA_W)
//   INADDRESS    write register index (0-7)
//   WRITE        write enable
//   OUT1ADDRESS  read port 1 register index
//   OUT2ADDRESS  read port 2 register index
//   OUT1, OUT2   read data, which feeds the operand-select mux downstream
//   REGVALID     bit i is set once register i has been written since the last reset
//   WRCOUNT      accepted writes since reset, saturating at 255
//
// Parameters
//   DATA_W   width of each register and of the data ports
//   FORWARD  1 bypasses IN to a read port that addresses the register being written
module reg_file #(
   parameter int DATA_W  = 8,
   parameter bit FORWARD = 1'b0
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [DATA_W-1:0] IN,
   input  logic [2:0]        INADDRESS,
   input  logic              WRITE,
   input  logic [2:0]        OUT1ADDRESS,
   input  logic [2:0]        OUT2ADDRESS,
   output logic [DATA_W-1:0] OUT1,
   output logic [DATA_W-1:0] OUT2,
   output logic [7:0]        REGVALID,
   output logic [7:0]        WRCOUNT
);

   localparam int          NUM_REGS = 8;
   localparam logic [7:0]  CNT_MAX  = 8'hFF;

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [7:0]        regvalid_q;
   logic [7:0]        wrcount_q;

   // A write counts only when reset is not asserted on the same edge.
   logic wr_accept;
   assign wr_accept = WRITE && !RESET;

   // Storage, valid flags and counter.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         regvalid_q <= 8'h00;
         wrcount_q  <= 8'h00;
      end else if (wr_accept) begin
         regs_q[INADDRESS]     <= IN;
         regvalid_q[INADDRESS] <= 1'b1;
         // The counter holds at its maximum rather than wrapping to zero.
         if (wrcount_q != CNT_MAX) begin
            wrcount_q <= wrcount_q + 8'd1;
         end
      end
   end

   // Plain array reads for both ports.
   logic [DATA_W-1:0] rd1_raw;
   logic [DATA_W-1:0] rd2_raw;

   always_comb begin
      rd1_raw = regs_q[OUT1ADDRESS];
      rd2_raw = regs_q[OUT2ADDRESS];
   end

   // Optional write-to-read bypass. It is gated by wr_accept, so a write that
   // reset is about to discard never appears on the read ports.
   generate
      if (FORWARD) begin : g_fwd
         logic hit1;
         logic hit2;

         always_comb begin
            hit1 = wr_accept && (OUT1ADDRESS == INADDRESS);
            hit2 = wr_accept && (OUT2ADDRESS == INADDRESS);
            OUT1 = rd1_raw;
            OUT2 = rd2_raw;
            if (hit1) begin
               OUT1 = IN;
            end
            if (hit2) begin
               OUT2 = IN;
            end
         end
      end else begin : g_nofwd
         always_comb begin
            OUT1 = rd1_raw;
            OUT2 = rd2_raw;
         end
      end
   endgenerate

   assign REGVALID = regvalid_q;
   assign WRCOUNT  = wrcount_q;

endmodule

// File: tb/tb_reg_file.sv
// Purpose : checks reg_file with FORWARD=0 and FORWARD=1 side by side against a behavioural model.
// Latency : expected reads are combinational; model state advances once per rising CLK edge.
// Backpr. : none; inputs are driven every cycle.
module tb_reg_file;

   localparam int DW = 8;

   logic          CLK;
   logic          RESET;
   logic [DW-1:0] IN;
   logic [2:0]    INADDRESS;
   logic          WRITE;
   logic [2:0]    OUT1ADDRESS;
   logic [2:0]    OUT2ADDRESS;

   logic [DW-1:0] out1_nf, out2_nf, out1_fw, out2_fw;
   logic [7:0]    regvalid_nf, wrcount_nf, regvalid_fw, wrcount_fw;

   int checks = 0;
   int errors = 0;

   // Reference model: plain arrays and an unbounded integer counter.
   int mdl_mem [8];
   int mdl_valid [8];
   int mdl_cnt;

   reg_file #(.DATA_W(DW), .FORWARD(1'b0)) dut_nf (
      .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
      .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
      .OUT1(out1_nf), .OUT2(out2_nf), .REGVALID(regvalid_nf), .WRCOUNT(wrcount_nf)
   );

   reg_file #(.DATA_W(DW), .FORWARD(1'b1)) dut_fw (
      .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
      .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
      .OUT1(out1_fw), .OUT2(out2_fw), .REGVALID(regvalid_fw), .WRCOUNT(wrcount_fw)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected read data for one port, given the current inputs.
   function automatic logic [31:0] exp_rd(input logic [2:0] a, input bit fwd);
      if (fwd && WRITE && !RESET && (a == INADDRESS)) return 32'(IN);
      return 32'(mdl_mem[a]);
   endfunction

   function automatic logic [31:0] exp_valid();
      int v = 0;
      for (int i = 0; i < 8; i++) if (mdl_valid[i] != 0) v += (1 << i);
      return 32'(v);
   endfunction

   function automatic logic [31:0] exp_cnt();
      return (mdl_cnt > 255) ? 32'd255 : 32'(mdl_cnt);
   endfunction

   // Compares every output of both instances against the model.
   task automatic check_all(input string tag);
      #1;
      cmp({tag, ".nf.out1"}, 32'(out1_nf), exp_rd(OUT1ADDRESS, 1'b0));
      cmp({tag, ".nf.out2"}, 32'(out2_nf), exp_rd(OUT2ADDRESS, 1'b0));
      cmp({tag, ".fw.out1"}, 32'(out1_fw), exp_rd(OUT1ADDRESS, 1'b1));
      cmp({tag, ".fw.out2"}, 32'(out2_fw), exp_rd(OUT2ADDRESS, 1'b1));
      cmp({tag, ".nf.valid"}, 32'(regvalid_nf), exp_valid());
      cmp({tag, ".fw.valid"}, 32'(regvalid_fw), exp_valid());
      cmp({tag, ".nf.cnt"}, 32'(wrcount_nf), exp_cnt());
      cmp({tag, ".fw.cnt"}, 32'(wrcount_fw), exp_cnt());
   endtask

   // Advances the model by the current inputs, then steps past the clock edge.
   task automatic tick();
      if (RESET) begin
         for (int i = 0; i < 8; i++) begin
            mdl_mem[i]   = 0;
            mdl_valid[i] = 0;
         end
         mdl_cnt = 0;
      end else if (WRITE) begin
         mdl_mem[INADDRESS]   = int'(IN);
         mdl_valid[INADDRESS] = 1;
         mdl_cnt++;
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [DW-1:0] d);
      WRITE = 1'b1; INADDRESS = a; IN = d;
      tick();
      WRITE = 1'b0;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
   endtask

   initial begin
      RESET = 1'b0; WRITE = 1'b0; IN = '0; INADDRESS = '0;
      OUT1ADDRESS = '0; OUT2ADDRESS = '0;
      for (int i = 0; i < 8; i++) begin
         mdl_mem[i] = 0;
         mdl_valid[i] = 0;
      end
      mdl_cnt = 0;

      // Reset, then sweep every read address.
      do_reset();
      for (int a = 0; a < 8; a++) begin
         OUT1ADDRESS = 3'(a); OUT2ADDRESS = 3'(7 - a);
         check_all("reset_sweep");
      end
      cmp("reset.valid_const", 32'(regvalid_nf), 32'h00);
      cmp("reset.cnt_const", 32'(wrcount_nf), 32'h00);

      // Basic write/read.
      wr(3'd3, 8'hA1);
      wr(3'd5, 8'h0F);
      OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd5;
      check_all("basic");
      cmp("basic.out1_const", 32'(out1_nf), 32'hA1);
      cmp("basic.out2_const", 32'(out2_nf), 32'h0F);
      cmp("basic.valid_const", 32'(regvalid_nf), 32'h28);
      cmp("basic.cnt_const", 32'(wrcount_nf), 32'd2);

      // Equal read addresses return the same data.
      OUT1ADDRESS = 3'd5; OUT2ADDRESS = 3'd5;
      check_all("same_addr");

      // Read during write, with and without bypass.
      wr(3'd2, 8'h11);
      WRITE = 1'b1; IN = 8'h22; INADDRESS = 3'd2; OUT1ADDRESS = 3'd2; OUT2ADDRESS = 3'd3;
      check_all("rdw_before");
      cmp("rdw.nf_before_const", 32'(out1_nf), 32'h11);
      cmp("rdw.fw_before_const", 32'(out1_fw), 32'h22);
      tick();
      WRITE = 1'b0;
      check_all("rdw_after");
      cmp("rdw.nf_after_const", 32'(out1_nf), 32'h22);

      // Reset colliding with a write; the bypass must stay off during reset.
      RESET = 1'b1; WRITE = 1'b1; IN = 8'hFF; INADDRESS = 3'd7; OUT1ADDRESS = 3'd7;
      check_all("collide_before");
      tick();
      RESET = 1'b0; WRITE = 1'b0;
      check_all("collide_after");
      cmp("collide.r7_const", 32'(out1_fw), 32'h00);
      cmp("collide.cnt_const", 32'(wrcount_fw), 32'h00);

      // Mid-operation reset.
      for (int r = 1; r <= 4; r++) wr(3'(r), 8'(8'h30 + r));
      OUT1ADDRESS = 3'd4; OUT2ADDRESS = 3'd1;
      check_all("mid_prereset");
      do_reset();
      check_all("mid_postreset");
      wr(3'd4, 8'h5A);
      OUT1ADDRESS = 3'd4;
      check_all("mid_rewrite");
      cmp("mid.r4_const", 32'(out1_nf), 32'h5A);
      cmp("mid.valid_const", 32'(regvalid_nf), 32'h10);

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 400; n++) begin
         RESET = ($urandom_range(0, 39) == 0);
         WRITE = $urandom_range(0, 1) == 1;
         IN = DW'($urandom);
         INADDRESS = 3'($urandom);
         OUT1ADDRESS = ($urandom_range(0, 3) == 0) ? INADDRESS : 3'($urandom);
         OUT2ADDRESS = ($urandom_range(0, 3) == 0) ? INADDRESS : 3'($urandom);
         check_all("random");
         tick();
      end
      RESET = 1'b0; WRITE = 1'b0;
      check_all("random_end");

      // Counter saturation.
      do_reset();
      OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd1;
      for (int n = 0; n < 260; n++) begin
         wr(3'd0, DW'(n));
         if (n >= 252) check_all("saturate");
      end
      cmp("sat.cnt_const", 32'(wrcount_nf), 32'd255);
      cmp("sat.valid_const", 32'(regvalid_fw), 32'h01);
      tick();
      check_all("sat_idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the width of each register and of the data ports.
REQ-002 The block SHALL have parameter FORWARD, default 0, meaning 1 enables write-to-read bypass and 0 disables it.
REQ-003 The block SHALL have port CLK  input  1  single clock, all state updates on rising edge.
REQ-004 The block SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port IN  input  DATA_W  write data.
REQ-006 The block SHALL have port INADDRESS  input  3  write register index.
REQ-007 The block SHALL have port WRITE  input  1  write enable.
REQ-008 The block SHALL have port OUT1ADDRESS  input  3  read port 1 register index.
REQ-009 The block SHALL have port OUT2ADDRESS  input  3  read port 2 register index.
REQ-010 The block SHALL have port OUT1  output  DATA_W  read port 1 data; feeds the operand-select mux downstream.
REQ-011 The block SHALL have port OUT2  output  DATA_W  read port 2 data; feeds the operand-select mux downstream.
REQ-012 The block SHALL have port REGVALID  output  8  bit i high means register i has been written since the last reset.
REQ-013 The block SHALL have port WRCOUNT  output  8  count of accepted writes since reset, saturating.

Function
REQ-014 The block SHALL hold 8 registers of DATA_W bits, indices 0-7; register 0 is an ordinary writable register, not hardwired.
REQ-015 The block SHALL write IN into register INADDRESS on a rising CLK edge when WRITE=1 and RESET=0; this is an "accepted write".
REQ-016 The block SHALL leave all registers unchanged on edges with WRITE=0.
REQ-017 The block SHALL drive OUT1/OUT2 combinationally from the register at OUT1ADDRESS/OUT2ADDRESS, with zero-cycle read latency.
REQ-018 Both read ports SHALL be independent; equal read addresses SHALL return identical data.
REQ-019 With FORWARD=0, a read of the register being written SHALL return the old value until the edge and the new value after it.
REQ-020 With FORWARD=1, while WRITE=1, RESET=0 and a read address equals INADDRESS, that OUT SHALL equal IN combinationally.
REQ-021 An accepted write SHALL set REGVALID[INADDRESS] at the same edge; bits are never cleared except by reset.
REQ-022 Each accepted write SHALL increment WRCOUNT by 1; at 255 it SHALL hold at 255, with no wrap.
REQ-023 Rewriting the same register SHALL still increment WRCOUNT and SHALL leave REGVALID unchanged.
REQ-024 X/undefined read addresses are out of scope; all 3-bit addresses SHALL be legal, with no out-of-range case.

Reset
REQ-025 On a rising CLK edge with RESET=1, all registers SHALL become 0, REGVALID SHALL become 8'h00 and WRCOUNT SHALL become 0.
REQ-026 RESET SHALL take priority over WRITE on the same edge, so the write is discarded and not counted.
REQ-027 After reset, OUT1 and OUT2 SHALL read 0 for every address.
REQ-028 With FORWARD=1, bypass SHALL be suppressed while RESET=1.
REQ-029 Reset SHALL have no asynchronous effect; state between RESET assertion and the next CLK edge is unchanged.

Verification
REQ-030 Reset then read all addresses: RESET=1 for one edge, sweep OUT1ADDRESS/OUT2ADDRESS 0-7 -> OUT1=OUT2=0, REGVALID=00, WRCOUNT=0.
REQ-031 Basic write/read: write 8'hA1 to r3 and 8'h0F to r5, then read OUT1ADDRESS=3 and OUT2ADDRESS=5 -> OUT1=A1, OUT2=0F, REGVALID=8'h28, WRCOUNT=2.
REQ-032 Read-during-write, FORWARD=0: r2=8'h11, set WRITE=1, IN=8'h22, INADDRESS=2, OUT1ADDRESS=2 -> OUT1=11 before edge, 22 after; FORWARD=1 -> OUT1=22 before edge.
REQ-033 Reset vs write collision: RESET=1 and WRITE=1 with IN=8'hFF to r7 on the same edge -> r7=0, REGVALID[7]=0, WRCOUNT=0.
REQ-034 Counter saturation: 260 accepted writes to r0 -> WRCOUNT=255 and holds; REGVALID=8'h01.
REQ-035 Mid-operation reset: after writes to r1-r4, assert RESET for one edge -> all outputs 0 next cycle, and a subsequent write of 8'h5A to r4 reads back 5A with REGVALID=8'h10.
